// File: rtl/syn_counter.sv
// -----------------------------------------------------------------------------
// syn_counter
//   Synchronous up/down counter with parallel load and a terminal-count flag.
//   At each rising clk edge the priority is: reset, load, count, hold.
//   Counting wraps silently modulo 2^WIDTH.
//
// Ports (positional order is fixed: clk, Rst, out, ld_en, load, cnt_en,
// up_dn, tc)
//   clk    in   1      single clock, rising edge
//   Rst    in   1      synchronous active-low reset, clears the count
//   out    out  WIDTH  registered counter value
//   ld_en  in   1      parallel-load enable, takes priority over counting
//   load   in   WIDTH  parallel-load value
//   cnt_en in   1      count enable
//   up_dn  in   1      direction: 1 = up, 0 = down
//   tc     out  1      terminal count: the next count step would wrap
// -----------------------------------------------------------------------------
module syn_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             Rst,
  output logic [WIDTH-1:0] out,
  input  logic             ld_en,
  input  logic [WIDTH-1:0] load,
  input  logic             cnt_en,
  input  logic             up_dn,
  output logic             tc
);

  localparam logic [WIDTH-1:0] L_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;
  logic             w_at_end;

  // Next-state selection below reset. Load beats count; neither means hold.
  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_count;
    if (ld_en) begin
      w_next = load;
    end else if (cnt_en) begin
      w_next = up_dn ? (r_count + L_ONE) : (r_count - L_ONE);
    end
  end

  // NOTE: reset is tested inside the clocked block, so it only acts on a
  // rising edge and never changes out between edges.
  always_ff @(posedge clk) begin
    if (!Rst) begin
      r_count <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values together.
      r_count <= w_next;
    end
  end

  // The end value depends on direction: all-ones counting up, zero counting
  // down. A pending load suppresses the flag because no count step happens.
  assign w_at_end = up_dn ? (&r_count) : (~|r_count);
  assign tc       = cnt_en & ~ld_en & w_at_end;

  assign out = r_count;

endmodule

// File: tb/tb_syn_counter.sv
// -----------------------------------------------------------------------------
// tb_syn_counter
//   Self-checking bench for syn_counter (WIDTH = 4). Each test task drives
//   one scenario; expected out values are pushed to a scoreboard queue when
//   a cycle is driven and popped and compared one time unit after the edge.
// -----------------------------------------------------------------------------
module tb_syn_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         Rst;
  logic [W-1:0] out;
  logic         ld_en;
  logic [W-1:0] load;
  logic         cnt_en;
  logic         up_dn;
  logic         tc;

  logic [W-1:0] sb_q[$];
  logic [W-1:0] exp_v;
  int           checks   = 0;
  int           failures = 0;

  syn_counter #(.WIDTH(W)) dut (
    .clk    (clk),
    .Rst    (Rst),
    .out    (out),
    .ld_en  (ld_en),
    .load   (load),
    .cnt_en (cnt_en),
    .up_dn  (up_dn),
    .tc     (tc)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, record the value out must take after the
  // coming edge, then advance to just past that edge.
  task automatic drive(input logic rst, input logic ld, input logic [W-1:0] ldv,
                       input logic cen, input logic ud, input logic [W-1:0] exp_out);
    Rst    = rst;
    ld_en  = ld;
    load   = ldv;
    cnt_en = cen;
    up_dn  = ud;
    sb_q.push_back(exp_out);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 4'h9, 1'b1, 1'b1, 4'h0);
      exp_v = sb_q.pop_front();
      checks++;
      if (out !== exp_v) begin
        failures++;
        $display("FAIL reset[%0d]: out=%h expected=%h", i, out, exp_v);
      end
    end
    // From the reset value, counting down is at its end: tc must be 1.
    ld_en = 1'b0; cnt_en = 1'b1; up_dn = 1'b0;
    #1;
    checks++;
    if (tc !== 1'b1) begin
      failures++;
      $display("FAIL reset_tc: tc=%b expected=1", tc);
    end
  endtask

  task automatic test_load_count();
    logic [W-1:0] seq [4] = '{4'h3, 4'h4, 4'h5, 4'h6};
    drive(1'b1, 1'b1, 4'b0011, 1'b0, 1'b0, seq[0]);
    exp_v = sb_q.pop_front();
    checks++;
    if (out !== exp_v) begin
      failures++;
      $display("FAIL load: out=%h expected=%h", out, exp_v);
    end
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 1'b0, 4'hA, 1'b1, 1'b1, seq[i]);
      exp_v = sb_q.pop_front();
      checks++;
      if (out !== exp_v) begin
        failures++;
        $display("FAIL count_up[%0d]: out=%h expected=%h", i, out, exp_v);
      end
    end
  endtask

  task automatic test_reload();
    // out is 6 here; an increment would give 7, the load must give 6 again.
    drive(1'b1, 1'b1, 4'b0110, 1'b1, 1'b1, 4'h6);
    exp_v = sb_q.pop_front();
    checks++;
    if (out !== exp_v) begin
      failures++;
      $display("FAIL reload_over_count: out=%h expected=%h", out, exp_v);
    end
    drive(1'b1, 1'b1, 4'h9, 1'b1, 1'b0, 4'h9);
    exp_v = sb_q.pop_front();
    checks++;
    if (out !== exp_v) begin
      failures++;
      $display("FAIL reload_over_down: out=%h expected=%h", out, exp_v);
    end
  endtask

  task automatic test_up_wrap();
    logic [W-1:0] seq [3] = '{4'hF, 4'h0, 4'h1};
    drive(1'b1, 1'b1, 4'hE, 1'b0, 1'b1, 4'hE);
    exp_v = sb_q.pop_front();
    checks++;
    if (out !== exp_v) begin
      failures++;
      $display("FAIL up_wrap_load: out=%h expected=%h", out, exp_v);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, seq[i]);
      exp_v = sb_q.pop_front();
      checks++;
      if (out !== exp_v) begin
        failures++;
        $display("FAIL up_wrap[%0d]: out=%h expected=%h", i, out, exp_v);
      end
      checks++;
      if (tc !== (i == 0)) begin
        failures++;
        $display("FAIL up_wrap_tc[%0d]: tc=%b expected=%b", i, tc, (i == 0));
      end
    end
  endtask

  task automatic test_down_wrap();
    logic [W-1:0] seq [3] = '{4'h0, 4'hF, 4'hE};
    drive(1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 4'h1);
    exp_v = sb_q.pop_front();
    checks++;
    if (out !== exp_v) begin
      failures++;
      $display("FAIL down_wrap_load: out=%h expected=%h", out, exp_v);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 4'h7, 1'b1, 1'b0, seq[i]);
      exp_v = sb_q.pop_front();
      checks++;
      if (out !== exp_v) begin
        failures++;
        $display("FAIL down_wrap[%0d]: out=%h expected=%h", i, out, exp_v);
      end
      checks++;
      if (tc !== (i == 0)) begin
        failures++;
        $display("FAIL down_wrap_tc[%0d]: tc=%b expected=%b", i, tc, (i == 0));
      end
    end
  endtask

  task automatic test_tc_gating();
    // Park the counter at all-ones, then walk the qualifying inputs.
    drive(1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 4'hF);
    exp_v = sb_q.pop_front();
    checks++;
    if (out !== exp_v) begin
      failures++;
      $display("FAIL tc_setup: out=%h expected=%h", out, exp_v);
    end
    ld_en = 1'b0; cnt_en = 1'b0; up_dn = 1'b1; #1;
    checks++;
    if (tc !== 1'b0) begin
      failures++;
      $display("FAIL tc_no_cnt_en: tc=%b expected=0", tc);
    end
    cnt_en = 1'b1; #1;
    checks++;
    if (tc !== 1'b1) begin
      failures++;
      $display("FAIL tc_up_full: tc=%b expected=1", tc);
    end
    ld_en = 1'b1; #1;
    checks++;
    if (tc !== 1'b0) begin
      failures++;
      $display("FAIL tc_ld_en_mask: tc=%b expected=0", tc);
    end
    ld_en = 1'b0; up_dn = 1'b0; #1;
    checks++;
    if (tc !== 1'b0) begin
      failures++;
      $display("FAIL tc_down_full: tc=%b expected=0", tc);
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 1'b1, 4'hB, 1'b0, 1'b0, 4'hB);
    void'(sb_q.pop_front());
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, W'(i), 1'b0, i[0], 4'hB);
      // Inputs wiggling between edges must not disturb out.
      load = 4'h2; up_dn = ~up_dn;
      #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (out !== exp_v) begin
        failures++;
        $display("FAIL hold[%0d]: out=%h expected=%h", i, out, exp_v);
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'hC);
    exp_v = sb_q.pop_front();
    checks++;
    if (out !== exp_v) begin
      failures++;
      $display("FAIL mid_count: out=%h expected=%h", out, exp_v);
    end
    // Dropping Rst between edges must not clear out immediately.
    Rst = 1'b0;
    #2;
    checks++;
    if (out !== 4'hC) begin
      failures++;
      $display("FAIL reset_not_async: out=%h expected=c", out);
    end
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h0);
    exp_v = sb_q.pop_front();
    checks++;
    if (out !== exp_v) begin
      failures++;
      $display("FAIL mid_reset: out=%h expected=%h", out, exp_v);
    end
    for (int i = 1; i <= 2; i++) begin
      drive(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, W'(i));
      exp_v = sb_q.pop_front();
      checks++;
      if (out !== exp_v) begin
        failures++;
        $display("FAIL resume[%0d]: out=%h expected=%h", i, out, exp_v);
      end
    end
    // Reset during a load also discards it.
    drive(1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 4'h0);
    exp_v = sb_q.pop_front();
    checks++;
    if (out !== exp_v) begin
      failures++;
      $display("FAIL reset_over_load: out=%h expected=%h", out, exp_v);
    end
  endtask

  initial begin
    Rst = 1'b0; ld_en = 1'b0; load = '0; cnt_en = 1'b0; up_dn = 1'b0;
    #1;
    test_reset();
    test_load_count();
    test_reload();
    test_up_wrap();
    test_down_wrap();
    test_tc_gating();
    test_hold();
    test_mid_reset();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: left=%0d expected=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
